mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 Parameter SIGNED_EN, default 1; when 1 the signed_mode input is honoured, when 0 signed_mode is ignored and all operations are unsigned.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand pair a/b/signed_mode is valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
REQ-010 out_valid  output  1  result is valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  2*WIDTH  product a*b.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL use a three-state FSM: IDLE, CALC, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE, a rising edge with in_valid=1 (accept edge) SHALL register a, b and the effective signed flag, clear the accumulator and bit counter, and move to CALC.
REQ-017 The effective signed flag SHALL be signed_mode AND SIGNED_EN.
REQ-018 On accept, a signed operation SHALL register the magnitudes of a and b (unsigned WIDTH bits; -2^(WIDTH-1) gives magnitude 2^(WIDTH-1)) and a negate flag = sign(a) XOR sign(b).
REQ-019 Each CALC cycle SHALL process one multiplier bit, LSB first: if the bit is 1, add the multiplicand shifted left by the bit index into a 2*WIDTH-bit accumulator; increment the counter.
REQ-020 After exactly WIDTH CALC cycles the FSM SHALL enter DONE, so out_valid rises on the WIDTH-th rising edge after the accept edge; latency is fixed and independent of operand values (no early exit for zero operands).
REQ-021 On the edge entering DONE, result SHALL be loaded with the accumulator, two's-complement negated over 2*WIDTH bits when the negate flag is set.
REQ-022 result SHALL be exact: unsigned range 0..(2^WIDTH-1)^2, signed range -2^(WIDTH-1)*(2^(WIDTH-1)-1)..2^(2*WIDTH-2); no truncation or saturation.
REQ-023 In DONE, result and out_valid SHALL hold stable until an edge with out_ready=1, which SHALL return the FSM to IDLE and clear out_valid.
REQ-024 in_valid during CALC or DONE SHALL be ignored (no queuing); upstream holds the pair until in_ready=1.
REQ-025 Changes on a, b or signed_mode after the accept edge SHALL NOT affect the operation in progress.
REQ-026 Maximum throughput SHALL be one product per WIDTH+2 cycles (accept, WIDTH CALC cycles, DONE handshake, IDLE).
REQ-027 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-028 An edge with rst=1 SHALL force IDLE, in_ready=1, out_valid=0, busy=0, result=0, and clear the accumulator, counter and negate flag, overriding all other inputs.
REQ-029 Reset during CALC or DONE SHALL abandon the operation; no out_valid pulse SHALL follow.
REQ-030 An in_valid presented on the same edge as rst=1 SHALL NOT be accepted.

Verification (WIDTH=4, SIGNED_EN=1)
REQ-031 Unsigned 3*3, out_ready=1 -> out_valid exactly 4 edges after accept, result=0x09, one cycle in DONE.
REQ-032 Unsigned 15*15 and 0*15 -> 0xE1 and 0x00, both at identical 4-cycle latency.
REQ-033 Signed -8*-8 -> 0x40; signed -3*5 -> 0xF1; signed -8*7 -> 0xC8; unsigned 8*8 (same bits as -8*-8) -> 0x40.
REQ-034 out_ready held low 5 cycles in DONE -> result/out_valid stable throughout, in_ready=0, a new in_valid ignored; IDLE one edge after out_ready=1.
REQ-035 rst=1 on second CALC cycle -> next cycle IDLE, in_ready=1, result=0, no out_valid; subsequent 2*6 -> 0x0C normally.
REQ-036 Operand inputs changed each cycle during CALC -> result matches the pair sampled at the accept edge.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential shift-and-add multiplier with a valid/ready handshake on both sides.
// Signed operands are multiplied as magnitudes and the product is negated at the end.
module mult_seq #(
    parameter int WIDTH     = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic SEN = (SIGNED_EN != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] res_nxt;
    logic               last;

    always_comb begin
        sgn   = signed_mode & SEN;
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        // Two's-complement of the most negative value wraps to 2^(W-1),
        // which is exactly its magnitude as an unsigned W-bit number.
        a_mag = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag = b_neg ? (~b + WIDTH'(1)) : b;
    end

    always_comb begin
        acc_nxt = acc;
        if (mplier[0])
            acc_nxt = acc + mcand;
        res_nxt = neg ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        mcand    <= {{WIDTH{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        neg      <= a_neg ^ b_neg;
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= res_nxt;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq at WIDTH=4, SIGNED_EN=1.
// Expected products are hand-computed constants.
module tb_mult_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       signed_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       busy;

    int passed = 0;
    int total  = 0;

    mult_seq #(.WIDTH(4), .SIGNED_EN(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one pair, wait for out_valid, check latency and product.
    // With scr set, operands are scrambled every CALC cycle.
    task automatic op(input string tag, input logic [3:0] xa,
                      input logic [3:0] xb, input logic sm,
                      input logic [7:0] exp, input bit scr);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, in_ready, 1'b1);
        a = xa;
        b = xb;
        signed_mode = sm;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, {in_ready, busy}, 2'b01);
        n = 0;
        while (!out_valid && n < 20) begin
            if (scr) begin
                a = 4'($urandom);
                b = 4'($urandom);
                signed_mode = 1'($urandom);
            end
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_res"}, result, exp);
        if (out_ready) begin
            tick();
            chk({tag, "_ret"}, {out_valid, in_ready, busy}, 3'b010);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        a = 4'd3;
        b = 4'd3;
        tick();
        chk("rst_state", {in_ready, out_valid, busy}, 3'b100);
        chk("rst_result", result, 8'h00);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rst_noacc", busy, 1'b0);

        op("u3x3", 4'd3, 4'd3, 1'b0, 8'h09, 1'b0);
        op("u15x15", 4'd15, 4'd15, 1'b0, 8'hE1, 1'b0);
        op("u0x15", 4'd0, 4'd15, 1'b0, 8'h00, 1'b0);
        op("sm8xm8", 4'h8, 4'h8, 1'b1, 8'h40, 1'b0);
        op("sm3x5", 4'hD, 4'd5, 1'b1, 8'hF1, 1'b0);
        op("sm8x7", 4'h8, 4'd7, 1'b1, 8'hC8, 1'b0);
        op("u8x8", 4'h8, 4'h8, 1'b0, 8'h40, 1'b0);
        op("s7xm1", 4'd7, 4'hF, 1'b1, 8'hF9, 1'b0);

        // Back-pressure: hold DONE for five cycles.
        out_ready = 1'b0;
        op("stall", 4'd3, 4'd4, 1'b0, 8'h0C, 1'b0);
        a = 4'd9;
        b = 4'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", {out_valid, in_ready, busy, result},
                {3'b101, 8'h0C});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_rel", {out_valid, in_ready, busy}, 3'b010);

        // Reset on the second CALC cycle abandons the operation.
        a = 4'd5;
        b = 4'd5;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", {in_ready, out_valid, busy}, 3'b100);
        chk("abort_res", result, 8'h00);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("abort_nov", seen, 0);
        end
        op("u2x6", 4'd2, 4'd6, 1'b0, 8'h0C, 1'b0);

        op("scr_u7x9", 4'd7, 4'd9, 1'b0, 8'h3F, 1'b1);
        op("scr_sm6x3", 4'hA, 4'd3, 1'b1, 8'hEE, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
